// File: rtl/dilator5.sv
// dilator5 - binary morphological dilation over a WIN_SIZE x WIN_SIZE window,
// applied to a raster mask stream driven by free-running hpos/vpos counters.
//
// WIN_SIZE-1 one-bit line memories hold the previous lines. A shift-register
// window is fed one column per pixel clock. Window cells whose image
// coordinate lies outside the frame are masked to 0. This prevents
// dilation across image borders, line wraps and frame wraps.
//
// Parameters:
//   H_IMG_RES   active pixels per line
//   V_IMG_RES   active lines per frame
//   WIN_SIZE    window side (odd, 3..7), R = WIN_SIZE/2
//   STRUCT_ELM  structuring element. Bit WIN_SIZE*(dy+R)+(dx+R) enables (dx,dy)
//
// Ports:
//   clk        pixel clock, rising edge
//   rst_n      synchronous active-low reset
//   hpos/vpos  raster column/line of in_pix
//   in_pix     mask pixel at (hpos,vpos)
//   out_pix    dilated pixel at (out_hpos,out_vpos), 0 when not valid
//   out_valid  out_pix belongs to an in-image centre
//   out_hpos   centre column (hpos-R, modulo 2^11)
//   out_vpos   centre line (vpos-R, modulo 2^11)
module dilator5 #(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int WIN_SIZE  = 5,
  parameter logic [WIN_SIZE*WIN_SIZE-1:0] STRUCT_ELM = 25'b01110_11111_11111_11111_01110
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        in_pix,
  output logic        out_pix,
  output logic        out_valid,
  output logic [10:0] out_hpos,
  output logic [10:0] out_vpos
);

  localparam int R  = WIN_SIZE / 2;
  localparam int NL = WIN_SIZE - 1;
  localparam int AW = $clog2(H_IMG_RES);
  localparam int PW = $clog2(NL);

  // Buffer index that holds the line written k lines after the oldest one.
  // The oldest buffer is the one about to be overwritten, selected by ptr.
  function automatic logic [PW-1:0] ring_row(input logic [PW-1:0] ptr, input int k);
    int s;
    s = (int'(ptr) + k) % NL;
    return PW'(s);
  endfunction

  // Returns true when pos+off is a legal coordinate in [0, lim-1].
  function automatic logic coord_ok(input logic [10:0] pos, input int off, input int lim);
    int p;
    p = int'(pos) + off;
    return (p >= 0) && (p < lim);
  endfunction

  logic                               line_mem [NL][H_IMG_RES];
  logic [PW-1:0]                      wr_ptr;
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0]  win;
  logic [WIN_SIZE-1:0][WIN_SIZE-1:0]  nxt_win;
  logic [WIN_SIZE-1:0]                new_col;
  logic [WIN_SIZE-1:0]                row_ok;
  logic [WIN_SIZE-1:0]                col_ok;
  logic                               primed;
  logic                               primed_nxt;
  logic                               valid_nxt;
  logic                               hit;
  logic                               h_active;
  logic                               shift_en;

  assign h_active = hpos < 11'(H_IMG_RES);
  assign shift_en = hpos < 11'(H_IMG_RES + R);

  // Line memories are deliberately not reset. Coordinate masking hides
  // any stale or blanking-period contents.
  always_ff @(posedge clk) begin
    if (h_active) begin
      line_mem[wr_ptr][hpos[AW-1:0]] <= in_pix;
    end
  end

  // The ring pointer advances at the last active column of every line,
  // blanking lines included, so buffer age always equals line distance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (hpos == 11'(H_IMG_RES - 1)) begin
      wr_ptr <= (wr_ptr == PW'(NL - 1)) ? '0 : wr_ptr + PW'(1);
    end
  end

  // Build the incoming column. Row WIN_SIZE-1 is the live pixel and rows
  // above it come from stored lines. The read happens before this cycle's
  // write, so the oldest buffer still holds line v-(WIN_SIZE-1).
  always_comb begin
    new_col = '0;
    if (h_active) begin
      for (int k = 0; k < NL; k++) begin
        new_col[k] = line_mem[ring_row(wr_ptr, k)][hpos[AW-1:0]];
      end
      new_col[WIN_SIZE-1] = in_pix;
    end
  end

  // Column WIN_SIZE-1 is the newest (dx=+R) and older columns slide
  // toward column 0 (dx=-R).
  always_comb begin
    nxt_win = '0;
    for (int r = 0; r < WIN_SIZE; r++) begin
      nxt_win[r] = {new_col[r], win[r][WIN_SIZE-1:1]};
    end
  end

  // Mask each window row and column by its image coordinate relative to
  // the centre (hpos-R, vpos-R), then OR the enabled, masked cells.
  always_comb begin
    row_ok = '0;
    col_ok = '0;
    hit    = 1'b0;
    for (int i = 0; i < WIN_SIZE; i++) begin
      col_ok[i] = coord_ok(hpos, i - 2 * R, H_IMG_RES);
      row_ok[i] = coord_ok(vpos, i - 2 * R, V_IMG_RES);
    end
    for (int r = 0; r < WIN_SIZE; r++) begin
      for (int c = 0; c < WIN_SIZE; c++) begin
        if (STRUCT_ELM[WIN_SIZE * r + c] && nxt_win[r][c] && row_ok[r] && col_ok[c]) begin
          hit = 1'b1;
        end
      end
    end
  end

  // primed includes the (0,0) cycle itself.
  always_comb begin
    primed_nxt = primed || ((hpos == 11'd0) && (vpos == 11'd0));
    valid_nxt  = primed_nxt &&
                 (hpos >= 11'(R)) && (hpos < 11'(H_IMG_RES + R)) &&
                 (vpos >= 11'(R)) && (vpos < 11'(V_IMG_RES + R));
  end

  // Window, primed flag and all outputs are registered. The output lags
  // the input that completes its window by one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      primed    <= 1'b0;
      win       <= '0;
      out_pix   <= 1'b0;
      out_valid <= 1'b0;
      out_hpos  <= '0;
      out_vpos  <= '0;
    end else begin
      primed <= primed_nxt;
      if (shift_en) begin
        win <= nxt_win;
      end
      out_valid <= valid_nxt;
      out_pix   <= valid_nxt && hit;
      out_hpos  <= hpos - 11'(R);
      out_vpos  <= vpos - 11'(R);
    end
  end

endmodule

// File: tb/tb_dilator5.sv
// tb_dilator5 - self-checking bench for dilator5 on a reduced 40x24 raster.
module tb_dilator5;

  localparam int H           = 40;
  localparam int V           = 24;
  localparam int W           = 5;
  localparam int R           = W / 2;
  localparam int HBLANK      = 3;
  localparam int VBLANK      = R;
  localparam int LINE_LEN    = H + HBLANK;
  localparam int FRAME_LINES = V + VBLANK;
  localparam logic [W*W-1:0] SE = 25'b01110_11111_11111_11111_01110;

  typedef struct {
    int id;
    int x;
    int y;
    bit exp;
  } spot_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hpos;
  logic [10:0] vpos;
  logic        in_pix;
  logic        out_pix;
  logic        out_valid;
  logic [10:0] out_hpos;
  logic [10:0] out_vpos;

  always #5 clk = ~clk;

  dilator5 #(
    .H_IMG_RES (H),
    .V_IMG_RES (V),
    .WIN_SIZE  (W),
    .STRUCT_ELM(SE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hpos     (hpos),
    .vpos     (vpos),
    .in_pix   (in_pix),
    .out_pix  (out_pix),
    .out_valid(out_valid),
    .out_hpos (out_hpos),
    .out_vpos (out_vpos)
  );

  bit img    [V][H];
  bit expmap [V][H];
  bit outmap [V][H];
  bit seen   [V][H];

  spot_t spots[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit          m_primed;
  bit          exp_valid;
  bit          exp_pix;
  logic [10:0] exp_h;
  logic [10:0] exp_v;
  int          cur_h;
  int          cur_v;

  bit lat_armed;
  int lat_x;
  int lat_y;
  int lat_in_cyc;
  int lat_out_cyc;

  bit          fv_armed;
  bit          fv_found;
  int          fv_in_h;
  int          fv_in_v;
  logic [10:0] fv_oh;
  logic [10:0] fv_ov;

  // Forward scatter: every set input pixel paints the centres it reaches.
  function automatic void build_expected();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        expmap[y][x] = 1'b0;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        if (img[y][x])
          for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++)
              if (SE[W * (dy + R) + (dx + R)] && (x - dx >= 0) && (x - dx < H) &&
                  (y - dy >= 0) && (y - dy < V))
                expmap[y - dy][x - dx] = 1'b1;
  endfunction

  function automatic void clear_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = 1'b0;
  endfunction

  function automatic void fill_img(input bit val);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = val;
  endfunction

  function automatic void random_img();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = ($urandom_range(0, 9) < 3);
  endfunction

  function automatic void add_spot(input int id, input int x, input int y, input bit e);
    spot_t s;
    s.id  = id;
    s.x   = x;
    s.y   = y;
    s.exp = e;
    spots.push_back(s);
  endfunction

  task automatic applyStimulus(input int h, input int v, input bit pix, input bit rstn);
    hpos   = 11'(h);
    vpos   = 11'(v);
    in_pix = pix;
    rst_n  = rstn;
    if (!rstn) begin
      m_primed  = 1'b0;
      exp_valid = 1'b0;
      exp_pix   = 1'b0;
      exp_h     = '0;
      exp_v     = '0;
    end else begin
      if (h == 0 && v == 0) m_primed = 1'b1;
      exp_valid = m_primed && (h >= R) && (h < H + R) && (v >= R) && (v < V + R);
      exp_h     = 11'(h - R);
      exp_v     = 11'(v - R);
      exp_pix   = 1'b0;
      if (exp_valid) exp_pix = expmap[v - R][h - R];
      if (lat_armed && h == lat_x && v == lat_y) lat_in_cyc = cyc;
    end
    cur_h = h;
    cur_v = v;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput();
    tests++;
    if ({out_valid, out_pix, out_hpos, out_vpos} !== {exp_valid, exp_pix, exp_h, exp_v}) begin
      fails++;
      $display("[TB] FAIL stream in=(%0d,%0d): got valid=%b pix=%b pos=(%0d,%0d), expected valid=%b pix=%b pos=(%0d,%0d)",
               cur_h, cur_v, out_valid, out_pix, out_hpos, out_vpos,
               exp_valid, exp_pix, exp_h, exp_v);
    end
    if (out_valid === 1'b1 && out_hpos < 11'(H) && out_vpos < 11'(V)) begin
      seen[out_vpos][out_hpos]   = 1'b1;
      outmap[out_vpos][out_hpos] = out_pix;
      if (lat_armed && out_hpos == 11'(lat_x) && out_vpos == 11'(lat_y)) begin
        lat_out_cyc = cyc;
        lat_armed   = 1'b0;
      end
    end
    if (fv_armed && out_valid === 1'b1) begin
      fv_armed = 1'b0;
      fv_found = 1'b1;
      fv_in_h  = cur_h;
      fv_in_v  = cur_v;
      fv_oh    = out_hpos;
      fv_ov    = out_vpos;
    end
  endtask

  // Drives lines start_v..end of one raster frame from img, with junk
  // pixels in blanking and an optional one-cycle reset at (rst_h,rst_v).
  task automatic run_frame(input int start_v, input int rst_h, input int rst_v);
    build_expected();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        seen[y][x]   = 1'b0;
        outmap[y][x] = 1'b0;
      end
    for (int v = start_v; v < FRAME_LINES; v++)
      for (int h = 0; h < LINE_LEN; h++) begin
        bit pix;
        pix = (h < H && v < V) ? img[v][h] : 1'($urandom_range(0, 1));
        applyStimulus(h, v, pix, !(h == rst_h && v == rst_v));
        checkOutput();
      end
  endtask

  task automatic check_spots(input int id);
    for (int i = 0; i < spots.size(); i++) begin
      if (spots[i].id == id) begin
        tests++;
        if (!(seen[spots[i].y][spots[i].x] && outmap[spots[i].y][spots[i].x] == spots[i].exp)) begin
          fails++;
          $display("[TB] FAIL spot id=%0d (%0d,%0d): got valid=%b pix=%b, expected valid=1 pix=%b",
                   id, spots[i].x, spots[i].y, seen[spots[i].y][spots[i].x],
                   outmap[spots[i].y][spots[i].x], spots[i].exp);
        end
      end
    end
  endtask

  initial begin
    lat_armed   = 1'b0;
    lat_in_cyc  = -1000;
    lat_out_cyc = 0;
    fv_armed    = 1'b0;
    fv_found    = 1'b0;
    m_primed    = 1'b0;

    add_spot(1, 0, 0, 0);   add_spot(1, H-1, V-1, 0); add_spot(1, 20, 12, 0);
    add_spot(2, 0, 0, 1);   add_spot(2, H-1, 0, 1);   add_spot(2, 0, V-1, 1);
    add_spot(2, H-1, V-1, 1); add_spot(2, 20, 12, 1);
    add_spot(3, 18, 11, 1); add_spot(3, 20, 10, 1);   add_spot(3, 18, 10, 0);
    add_spot(3, 23, 12, 0); add_spot(3, 20, 12, 1);   add_spot(3, 22, 13, 1);
    add_spot(3, 21, 14, 1); add_spot(3, 22, 14, 0);
    add_spot(4, 0, 0, 1);   add_spot(4, 1, 0, 1);     add_spot(4, 2, 0, 1);
    add_spot(4, 0, 1, 1);   add_spot(4, 1, 1, 1);     add_spot(4, 2, 1, 1);
    add_spot(4, 0, 2, 1);   add_spot(4, 1, 2, 1);     add_spot(4, 2, 2, 0);
    add_spot(4, 3, 0, 0);   add_spot(4, H-1, 0, 0);   add_spot(4, H-1, 1, 0);
    add_spot(4, 0, V-1, 0); add_spot(4, 0, V-2, 0);
    add_spot(5, H-3, 9, 1); add_spot(5, H-1, 11, 1);  add_spot(5, H-2, 10, 1);
    add_spot(5, H-3, 11, 1); add_spot(5, 0, 10, 0);   add_spot(5, 0, 11, 0);
    add_spot(5, 1, 11, 0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(5, 5, 1'b1, 1'b0);
      checkOutput();
    end

    clear_img();
    run_frame(V - 3, -1, -1);

    fill_img(1'b0);
    run_frame(0, -1, -1);
    check_spots(1);

    fill_img(1'b1);
    run_frame(0, -1, -1);
    check_spots(2);

    clear_img();
    img[12][20] = 1'b1;
    lat_x = 20;
    lat_y = 12;
    lat_armed = 1'b1;
    run_frame(0, -1, -1);
    check_spots(3);
    tests++;
    if (lat_armed || (lat_out_cyc - lat_in_cyc) != 2 * LINE_LEN + 3) begin
      fails++;
      $display("[TB] FAIL latency: got %0d cycles (seen=%b), expected %0d",
               lat_out_cyc - lat_in_cyc, !lat_armed, 2 * LINE_LEN + 3);
    end
    lat_armed = 1'b0;

    clear_img();
    img[0][0] = 1'b1;
    run_frame(0, -1, -1);
    check_spots(4);

    clear_img();
    img[10][H-1] = 1'b1;
    run_frame(0, -1, -1);
    check_spots(5);

    clear_img();
    img[6][20]  = 1'b1;
    img[10][20] = 1'b1;
    img[14][20] = 1'b1;
    run_frame(0, -1, -1);
    for (int y = 3; y <= 17; y++) begin
      bit want;
      want = (y >= 4 && y <= 16);
      tests++;
      if (!(seen[y][20] && outmap[y][20] == want)) begin
        fails++;
        $display("[TB] FAIL ring col20 row %0d: got valid=%b pix=%b, expected valid=1 pix=%b",
                 y, seen[y][20], outmap[y][20], want);
      end
    end

    for (int f = 0; f < 3; f++) begin
      random_img();
      run_frame(0, -1, -1);
    end

    random_img();
    run_frame(0, 7, 10);

    random_img();
    fv_armed = 1'b1;
    fv_found = 1'b0;
    run_frame(0, -1, -1);
    tests++;
    if (!fv_found || fv_in_h != R || fv_in_v != R || fv_oh != 11'd0 || fv_ov != 11'd0) begin
      fails++;
      $display("[TB] FAIL first valid after reset: got found=%b in=(%0d,%0d) out=(%0d,%0d), expected in=(%0d,%0d) out=(0,0)",
               fv_found, fv_in_h, fv_in_v, fv_oh, fv_ov, R, R);
    end
    fv_armed = 1'b0;

    random_img();
    run_frame(0, 0, 0);

    random_img();
    run_frame(0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
